// File: rtl/delay_arbiter_if.sv
// Request/acknowledge bundle shared between the requesters (master side)
// and the delay arbiter (slave side).
interface delay_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DLY_W = 8,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*DLY_W-1:0] dly;
  logic [N_REQ-1:0]       ack;
  logic                   busy;
  logic [ID_W-1:0]        grant_id;

  modport master (output req, dly, input ack, busy, grant_id);
  modport slave  (input req, dly, output ack, busy, grant_id);
endinterface

// File: rtl/delay_arbiter.sv
// delay_arbiter: N_REQ requesters share one delay counter. The winner's delay
// is captured at grant, counted down, then acknowledged with a four-phase
// handshake. Selection is round-robin by default; defining the macro
// DELAY_ARB_FIXED_PRIO_EN switches to fixed priority (lowest index wins).
module delay_arbiter #(
  parameter int N_REQ = 4,
  parameter int DLY_W = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input logic           clk,
  input logic           rst,
  delay_arbiter_if.slave bus
);

  localparam logic [1:0]      IDLE     = 2'b00;
  localparam logic [1:0]      COUNT    = 2'b01;
  localparam logic [1:0]      ACK      = 2'b10;
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);

  // One-hot decode of a requester index.
  function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (id == ID_W'(i)) begin
        oh[i] = 1'b1;
      end else begin
        oh[i] = 1'b0;
      end
    end
    return oh;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  gid_q, gid_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             busy_q;

  logic             lo_found_s;
  logic [ID_W-1:0]  lo_idx_s;
  logic [ID_W-1:0]  win_s;
  logic [DLY_W-1:0] win_dly_s;
  logic             req_gnt_s;

  // Lowest-index asserted request (fixed priority, and round-robin wrap-around).
  always_comb begin
    lo_found_s = 1'b0;
    lo_idx_s   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.req[i] && !lo_found_s) begin
        lo_found_s = 1'b1;
        lo_idx_s   = ID_W'(i);
      end else begin
        lo_found_s = lo_found_s;
      end
    end
  end

`ifdef DELAY_ARB_FIXED_PRIO_EN
  assign win_s = lo_idx_s;
`else
  logic            hi_found_s;
  logic [ID_W-1:0] hi_idx_s;

  // Round-robin: first request above the last winner, else wrap to the lowest.
  always_comb begin
    hi_found_s = 1'b0;
    hi_idx_s   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.req[i] && !hi_found_s && (ID_W'(i) > last_q)) begin
        hi_found_s = 1'b1;
        hi_idx_s   = ID_W'(i);
      end else begin
        hi_found_s = hi_found_s;
      end
    end
    if (hi_found_s) begin
      win_s = hi_idx_s;
    end else begin
      win_s = lo_idx_s;
    end
  end
`endif

  // Select the winner's delay slice and the granted requester's req bit.
  always_comb begin
    win_dly_s = '0;
    req_gnt_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_s == ID_W'(i)) begin
        win_dly_s = bus.dly[i*DLY_W +: DLY_W];
      end else begin
        win_dly_s = win_dly_s;
      end
      if (gid_q == ID_W'(i)) begin
        req_gnt_s = bus.req[i];
      end else begin
        req_gnt_s = req_gnt_s;
      end
    end
  end

  // Next-state logic for the IDLE/COUNT/ACK controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gid_d   = gid_q;
    last_d  = last_q;
    ack_d   = ack_q;
    case (state_q)
      IDLE: begin
        if (lo_found_s) begin
          state_d = COUNT;
          gid_d   = win_s;
          cnt_d   = win_dly_s;
        end else begin
          state_d = IDLE;
        end
      end
      COUNT: begin
        if (!req_gnt_s) begin
          // Requester withdrew before the delay expired: no ack.
          state_d = IDLE;
          last_d  = gid_q;
        end else if (cnt_q == '0) begin
          state_d = ACK;
          ack_d   = id_to_onehot(gid_q);
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      ACK: begin
        if (!req_gnt_s) begin
          state_d = IDLE;
          ack_d   = '0;
          last_d  = gid_q;
        end else begin
          ack_d = ack_q;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = '0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gid_q   <= '0;
      last_q  <= LAST_RST;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.ack      = ack_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = gid_q;

endmodule
